// File: rtl/nibadd_pkg.sv
// Shared constants and types for the nibble-serial adder sequencer.
// Also provides the idx-width helper that the top uses to size its nibble counter.
package nibadd_pkg;
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction
endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry slice used by the nibble-serial sequencer.
module nibble_adder
    import nibadd_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);
    logic [NIB_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar g = 0; g < NIB_W; g++) begin : g_bit
        assign sum[g]    = a[g] ^ b[g] ^ w_c[g];
        assign w_c[g+1]  = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
    end

    assign cout = w_c[NIB_W];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Runs a WORD_NIBBLES*4-bit add through one 4-bit slice, LSB nibble first, with valid/ready ports.
// Define NIBADD_SUB_EN to add the in_sub port (A-B via ~B and a forced carry-in of 1).
module nibble_serial_add_ctrl
    import nibadd_pkg::*;
#(
    parameter int WORD_NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIB_W*WORD_NIBBLES-1:0] in_a,
    input  logic [NIB_W*WORD_NIBBLES-1:0] in_b,
    input  logic                      in_cin,
`ifdef NIBADD_SUB_EN
    input  logic                      in_sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIB_W*WORD_NIBBLES-1:0] out_sum,
    output logic                      out_cout,
    output logic                      busy
);
    localparam int W     = NIB_W * WORD_NIBBLES;
    localparam int IDX_W = idx_width(WORD_NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_NIBBLES - 1);

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W-1:0]     r_a, r_b, r_sum;
    logic             r_cout, r_valid;

    logic [W-1:0]     w_b_lat;
    logic             w_cin_lat;
    logic [NIB_W-1:0] w_nib_a, w_nib_b, w_nib_sum;
    logic             w_nib_cout;
    logic             w_last;

`ifdef NIBADD_SUB_EN
    // Subtraction is A + ~B + 1; the transform is applied once at accept time.
    assign w_b_lat   = in_sub ? ~in_b : in_b;
    assign w_cin_lat = in_sub | in_cin;
`else
    assign w_b_lat   = in_b;
    assign w_cin_lat = in_cin;
`endif

    assign w_nib_a = r_a[NIB_W*r_idx +: NIB_W];
    assign w_nib_b = r_b[NIB_W*r_idx +: NIB_W];
    assign w_last  = (r_idx == LAST_IDX);

    nibble_adder u_slice (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .sum  (w_nib_sum),
        .cout (w_nib_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= w_b_lat;
                        r_carry <= w_cin_lat;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[NIB_W*r_idx +: NIB_W] <= w_nib_sum;
                    r_carry                     <= w_nib_cout;
                    if (w_last) begin
                        r_cout  <= w_nib_cout;
                        r_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: vector table, randomized ops against an arithmetic model, and stall/reset sequences.
module tb_nibble_serial_add_ctrl;
    localparam int WN = 4;
    localparam int W  = 4 * WN;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_cout, busy;
    logic [W-1:0] out_sum;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WORD_NIBBLES(WN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef NIBADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain W+1-bit arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        return r;
    endfunction

    // Issue one op, wait for the result (bounded), stall stall_cycles, then accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int stall,
                          output logic [W-1:0] s, output logic c, output int lat);
        int n;
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        n = 0;
        lat = -1;
        while (n < 20) begin
            @(posedge clk);
            #1 n++;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        s = out_sum;
        c = out_cout;
        if (lat < 0) begin
            chk("result_timeout", 32'd0, 32'd1);
            return;
        end
        repeat (stall) @(posedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("in_ready_after_accept", 32'(in_ready), 32'd1);
        chk("out_valid_after_accept", 32'(out_valid), 32'd0);
    endtask

    vec_t vt[$];

    initial begin
        logic [W-1:0] s, hold_s;
        logic         c, hold_c;
        logic [W:0]   m;
        int           lat;

        vt.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
        vt.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vt.push_back('{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0});
        vt.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
        vt.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
        vt.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
        vt.push_back('{16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0});
`ifdef NIBADD_SUB_EN
        vt.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
        vt.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        vt.push_back('{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1});
`endif

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_cout",  32'(out_cout),  32'd0);
        @(negedge clk) rst_n = 1'b1;

        foreach (vt[i]) begin
            run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 0, s, c, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_sum", i), 32'(s), 32'(vt[i].sum));
            chk($sformatf("vec%0d_cout", i), 32'(c), 32'(vt[i].cout));
        end

        // Stall in DONE with an ignored request.
        @(negedge clk);
        in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        hold_s = out_sum; hold_c = out_cout;
        chk("stall_sum", 32'(hold_s), 32'h0000BCDE);
        chk("stall_cout", 32'(hold_c), 32'd0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_a = 16'h5A5A; in_b = 16'hA5A5;
            @(posedge clk);
            #1;
            chk("stall_hold_sum",   32'(out_sum),   32'(hold_s));
            chk("stall_hold_cout",  32'(out_cout),  32'(hold_c));
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready",   32'(in_ready),  32'd0);
            chk("stall_busy",       32'(busy),      32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("stall_release_in_ready",  32'(in_ready),  32'd1);
        chk("stall_release_out_valid", 32'(out_valid), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("ignored_req_no_result", 32'(out_valid), 32'd0);
        chk("ignored_req_not_busy",  32'(busy),      32'd0);

        // Reset two clocks into RUN.
        @(negedge clk);
        in_a = 16'hFFFF; in_b = 16'h0001; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_busy",      32'(busy),      32'd0);
        chk("midrun_rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrun_no_stale_result", 32'(out_valid), 32'd0);
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0, s, c, lat);
        chk("post_rst_sum",  32'(s), 32'h00001010);
        chk("post_rst_cout", 32'(c), 32'd0);
        chk("post_rst_latency", 32'(lat), 32'd4);

        // Randomized ops against the arithmetic model.
        for (int r = 0; r < 60; r++) begin
            logic [W-1:0] ra, rb;
            logic         rc, rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef NIBADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            m = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), s, c, lat);
            chk("rand_latency", 32'(lat), 32'd4);
            chk("rand_sum",     32'(s),   32'(m[W-1:0]));
            chk("rand_cout",    32'(c),   32'(m[W]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
